// File: rtl/fetch_pkg.sv
// Shared definitions for the Thumb instruction fetch unit.
package fetch_pkg;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned WADDR_W = 10;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned HW_W    = 16;

    // Leading five bits of a halfword that opens a 32-bit Thumb encoding
    localparam logic [4:0] THUMB32_PFX0 = 5'b11101;
    localparam logic [4:0] THUMB32_PFX1 = 5'b11110;
    localparam logic [4:0] THUMB32_PFX2 = 5'b11111;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;

    function automatic logic is_thumb32(input logic [4:0] top5);
        return (top5 == THUMB32_PFX0) || (top5 == THUMB32_PFX1) || (top5 == THUMB32_PFX2);
    endfunction

endpackage

// File: rtl/fetch_hw_queue.sv
// Halfword FIFO: pushes 0-2 halfwords, pops 0-2 halfwords, flushable.
module fetch_hw_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [1:0]               push_n,
    input  logic [HW_W-1:0]          push_d0,
    input  logic [HW_W-1:0]          push_d1,
    input  logic [1:0]               pop_n,
    output logic [HW_W-1:0]          head0,
    output logic [HW_W-1:0]          head1,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [HW_W-1:0] mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    // Storage write; push_d0 always lands first in address order
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (push_n != 2'd0) mem[wr_ptr] <= push_d0;
            if (push_n == 2'd2) mem[wr_ptr + 1'b1] <= push_d1;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_n);
            rd_ptr <= rd_ptr + AW'(pop_n);
            count  <= count + (AW+1)'(push_n) - (AW+1)'(pop_n);
        end
    end

    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr + 1'b1];

endmodule

// File: rtl/fetch_unit.sv
// Thumb fetch unit: reads 32-bit flash words into a halfword queue and
// presents whole 16/32-bit instructions to the decoder.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 12'h000,
    parameter int unsigned       QDEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                branch_valid,
    input  logic [ADDR_W-1:0]   branch_addr,
    output logic                ld_flash,
    output logic [WADDR_W-1:0]  flash_addr_PC,
    input  logic                flash_busy,
    input  logic [DATA_W-1:0]   dout_flash,
    output logic                instr_valid,
    output logic [DATA_W-1:0]   instr,
    output logic                instr_is32,
    output logic [ADDR_W-1:0]   instr_pc,
    input  logic                instr_ready
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    fetch_state_t        state_q, state_d;
    logic                drop_q, drop_d;
    logic                skip_lo_q, skip_lo_d;
    logic [WADDR_W-1:0]  faddr_q, faddr_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;

    logic                q_flush;
    logic [1:0]          push_n, pop_n;
    logic [HW_W-1:0]     push_d0, head0, head1;
    logic [CW-1:0]       q_count, q_free;
    logic                h0_32, accept, capture;

    fetch_hw_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .flush   (q_flush),
        .push_n  (push_n),
        .push_d0 (push_d0),
        .push_d1 (dout_flash[31:16]),
        .pop_n   (pop_n),
        .head0   (head0),
        .head1   (head1),
        .count   (q_count)
    );

    assign q_free  = CW'(QDEPTH) - q_count;
    assign accept  = (state_q == REQ)  && !flash_busy;
    assign capture = (state_q == WAIT) && !flash_busy;
    assign h0_32   = is_thumb32(head0[15:11]);
    assign push_d0 = skip_lo_q ? dout_flash[31:16] : dout_flash[15:0];

    assign ld_flash      = (state_q == REQ);
    assign flash_addr_PC = faddr_q;
    assign instr_pc      = pc_q;
    assign instr_valid   = (q_count != '0) && (!h0_32 || (q_count >= CW'(2)));
    assign instr_is32    = instr_valid && h0_32;
    assign instr         = !instr_valid ? '0 :
                           h0_32 ? {head0, head1} : {16'h0000, head0};

    // State and address registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            drop_q    <= 1'b0;
            skip_lo_q <= RESET_PC[1];
            faddr_q   <= RESET_PC[11:2];
            pc_q      <= RESET_PC & ~12'h001;
        end else begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            skip_lo_q <= skip_lo_d;
            faddr_q   <= faddr_d;
            pc_q      <= pc_d;
        end
    end

    // Next-state, queue control and redirect handling
    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        skip_lo_d = skip_lo_q;
        faddr_d   = faddr_q;
        pc_d      = pc_q;
        q_flush   = 1'b0;
        push_n    = 2'd0;
        pop_n     = 2'd0;
        if (branch_valid) begin
            q_flush   = 1'b1;
            faddr_d   = branch_addr[11:2];
            pc_d      = branch_addr & ~12'h001;
            skip_lo_d = branch_addr[1];
            // A read still in flight keeps the FSM in WAIT so only one request
            // is ever outstanding; its data is discarded when it returns.
            unique case (state_q)
                REQ: begin
                    state_d = accept ? WAIT : REQ;
                    drop_d  = accept;
                end
                WAIT: begin
                    state_d = capture ? REQ : WAIT;
                    drop_d  = !capture;
                end
                default: begin
                    state_d = REQ;
                    drop_d  = 1'b0;
                end
            endcase
        end else begin
            if (instr_valid && instr_ready) begin
                pop_n = h0_32 ? 2'd2 : 2'd1;
                pc_d  = pc_q + (h0_32 ? 12'd4 : 12'd2);
            end
            unique case (state_q)
                IDLE: if (q_free >= CW'(2)) state_d = REQ;
                REQ:  if (accept) state_d = WAIT;
                WAIT: begin
                    if (capture) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = REQ;
                        end else begin
                            push_n    = skip_lo_q ? 2'd1 : 2'd2;
                            skip_lo_d = 1'b0;
                            faddr_d   = faddr_q + 10'd1;
                            state_d   = (q_free >= CW'(4)) ? REQ : IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
